// File: rtl/reg_access_master.sv
// Command-driven initiator for a single WIDTH-bit register: sequences write/read strobes,
// waits out the register's read latency and returns one response per command.
module reg_access_master #(
    parameter int WIDTH  = 8,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             reg_w_en,
    output logic             reg_r_en,
    output logic [WIDTH-1:0] reg_wdata,
    input  logic [WIDTH-1:0] reg_rdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic             busy,
    output logic [7:0]       err_count
);

    typedef enum logic [2:0] {IDLE, WR, RD, WAIT, RSP} state_t;
    typedef enum logic [1:0] {OP_NOP = 2'b00, OP_WRITE = 2'b01, OP_READ = 2'b10, OP_WV = 2'b11} op_t;

    localparam logic [2:0] LAT_LOAD = 3'(RD_LAT);

    state_t           state_q, state_d;
    op_t              op_q;
    logic [WIDTH-1:0] data_q;
    logic [2:0]       cnt_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic             rsp_err_q;
    logic [7:0]       err_count_q;
    logic             armed_q;

    logic accept;
    logic last_wait;
    logic rsp_done;

    // armed_q keeps cmd_ready low until the first clock edge after reset release.
    assign cmd_ready = (state_q == IDLE) && armed_q;
    assign accept    = cmd_valid && cmd_ready;
    assign last_wait = (state_q == WAIT) && (cnt_q == 3'd1);
    assign rsp_done  = (state_q == RSP) && rsp_ready;

    assign reg_w_en  = (state_q == WR);
    assign reg_r_en  = (state_q == RD);
    assign reg_wdata = (state_q == WR || state_q == RD) ? data_q : '0;
    assign rsp_valid = (state_q == RSP);
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = (state_q == RSP) && rsp_err_q;
    assign busy      = (state_q != IDLE);
    assign err_count = err_count_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (op_t'(cmd_op))
                        OP_NOP:          state_d = RSP;
                        OP_WRITE, OP_WV: state_d = WR;
                        default:         state_d = RD;
                    endcase
                end
            end
            WR:      state_d = (op_q == OP_WV) ? RD : RSP;
            RD:      state_d = WAIT;
            WAIT:    if (cnt_q == 3'd1) state_d = RSP;
            RSP:     if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed_q     <= 1'b0;
            op_q        <= OP_NOP;
            data_q      <= '0;
            cnt_q       <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            armed_q <= 1'b1;

            if (accept) begin
                op_q   <= op_t'(cmd_op);
                data_q <= (op_t'(cmd_op) == OP_WRITE || op_t'(cmd_op) == OP_WV) ? cmd_data : '0;
            end

            if (state_q == RD)        cnt_q <= LAT_LOAD;
            else if (state_q == WAIT) cnt_q <= cnt_q - 3'd1;

            // Response payload is captured on entry to RSP and held through backpressure.
            if (accept && op_t'(cmd_op) == OP_NOP) begin
                rsp_data_q <= '0;
                rsp_err_q  <= 1'b0;
            end else if (state_q == WR && op_q == OP_WRITE) begin
                rsp_data_q <= data_q;
                rsp_err_q  <= 1'b0;
            end else if (last_wait) begin
                rsp_data_q <= reg_rdata;
                rsp_err_q  <= (op_q == OP_WV) && (reg_rdata != data_q);
            end

            if (rsp_done && rsp_err_q && err_count_q != 8'hFF)
                err_count_q <= err_count_q + 8'd1;
        end
    end

endmodule

// File: tb/tb_reg_access_master.sv
// Directed bench for reg_access_master: RD_LAT=1 and RD_LAT=3 instances, each driving
// a small register model (optional stuck-at-0 on bit 0 for the RD_LAT=1 model).
module tb_reg_access_master;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    always #5 clk = ~clk;

    logic       sel = 1'b0;          // 0: RD_LAT=1 instance, 1: RD_LAT=3 instance
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_data = 8'h00;
    logic       rsp_ready = 1'b0;

    logic       cr1, we1, re1, rv1, rerr1, busy1;
    logic [7:0] wd1, rd1, rdt1, ec1;
    logic       cr3, we3, re3, rv3, rerr3, busy3;
    logic [7:0] wd3, rd3, rdt3, ec3;

    reg_access_master #(.WIDTH(8), .RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid && !sel), .cmd_ready(cr1),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .reg_w_en(we1), .reg_r_en(re1),
        .reg_wdata(wd1), .reg_rdata(rd1), .rsp_valid(rv1), .rsp_ready(rsp_ready),
        .rsp_data(rdt1), .rsp_err(rerr1), .busy(busy1), .err_count(ec1)
    );

    reg_access_master #(.WIDTH(8), .RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid && sel), .cmd_ready(cr3),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .reg_w_en(we3), .reg_r_en(re3),
        .reg_wdata(wd3), .reg_rdata(rd3), .rsp_valid(rv3), .rsp_ready(rsp_ready),
        .rsp_data(rdt3), .rsp_err(rerr3), .busy(busy3), .err_count(ec3)
    );

    logic       cr_m, we_m, re_m, rv_m, rerr_m, busy_m;
    logic [7:0] wd_m, rdt_m, ec_m;
    assign cr_m   = sel ? cr3   : cr1;
    assign we_m   = sel ? we3   : we1;
    assign re_m   = sel ? re3   : re1;
    assign rv_m   = sel ? rv3   : rv1;
    assign rerr_m = sel ? rerr3 : rerr1;
    assign busy_m = sel ? busy3 : busy1;
    assign wd_m   = sel ? wd3   : wd1;
    assign rdt_m  = sel ? rdt3  : rdt1;
    assign ec_m   = sel ? ec3   : ec1;

    // Register models: out is valid RD_LAT cycles after the r_en cycle.
    logic       stuck = 1'b0;
    logic [7:0] q1 = 8'h00, p1 = 8'h00;
    logic [7:0] q3 = 8'h3C;
    logic [7:0] p3 [3] = '{8'h00, 8'h00, 8'h00};
    assign rd1 = p1;
    assign rd3 = p3[2];

    always @(posedge clk) begin
        if (we1) q1 <= stuck ? (wd1 & 8'hFE) : wd1;
        if (re1) p1 <= q1;
        if (we3) q3 <= wd3;
        p3[0] <= re3 ? q3 : p3[0];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end

    int cyc = 0, wcnt = 0, rcnt = 0, wcyc = 0, rcyc = 0, overlap = 0;
    logic [7:0] wlast = 8'h00;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (we_m) begin
            wcnt  <= wcnt + 1;
            wcyc  <= cyc;
            wlast <= wd_m;
        end
        if (re_m) begin
            rcnt <= rcnt + 1;
            rcyc <= cyc;
        end
        if ((we1 && re1) || (we3 && re3)) overlap <= overlap + 1;
    end

    int checks = 0, failures = 0;
    int exp_ec = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Issue one command with rsp_ready high; check latency, strobes, payload and err_count.
    task automatic do_cmd(input string tag, input logic [1:0] op, input logic [7:0] data,
                          input logic [7:0] exp_data, input logic exp_err, input int exp_lat);
        int n, w0, r0, exp_w, exp_r;
        check({tag, ":cmd_ready"}, cr_m, 1);
        w0 = wcnt;
        r0 = rcnt;
        cmd_op    = op;
        cmd_data  = data;
        cmd_valid = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 1;
        while (!rv_m && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, ":latency"}, n, exp_lat);
        check({tag, ":rsp_data"}, rdt_m, exp_data);
        check({tag, ":rsp_err"}, rerr_m, exp_err);
        exp_w = (op == 2'b01 || op == 2'b11) ? 1 : 0;
        exp_r = (op == 2'b10 || op == 2'b11) ? 1 : 0;
        check({tag, ":w_pulses"}, wcnt - w0, exp_w);
        check({tag, ":r_pulses"}, rcnt - r0, exp_r);
        if (exp_w == 1) check({tag, ":wdata"}, wlast, data);
        if (op == 2'b11) check({tag, ":w_then_r"}, rcyc - wcyc, 1);
        if (exp_err && exp_ec < 255) exp_ec++;
        @(negedge clk);
        check({tag, ":rsp_valid_drop"}, rv_m, 0);
        check({tag, ":ready_again"}, cr_m, 1);
        check({tag, ":err_count"}, ec_m, exp_ec);
    endtask

    initial begin
        int n, w0, r0;
        logic seen;

        // Reset state
        @(negedge clk);
        check("rst:outs1", {cr1, we1, re1, wd1, rv1, rdt1, rerr1, busy1, ec1}, 0);
        check("rst:outs3", {cr3, we3, re3, wd3, rv3, rdt3, rerr3, busy3, ec3}, 0);
        rst = 1'b1;
        #1;
        check("rst:ready_before_edge", cr1, 0);
        @(negedge clk);
        check("rst:ready_after_edge", cr1, 1);
        check("rst:ready_after_edge3", cr3, 1);

        do_cmd("write_9d", 2'b01, 8'h9D, 8'h9D, 1'b0, 2);
        do_cmd("read_9d", 2'b10, 8'hFF, 8'h9D, 1'b0, 3);
        do_cmd("nop", 2'b00, 8'h77, 8'h00, 1'b0, 1);
        do_cmd("wv_8d", 2'b11, 8'h8D, 8'h8D, 1'b0, 4);

        // READ with backpressure; commands offered meanwhile must be ignored
        cmd_op    = 2'b10;
        cmd_valid = 1'b1;
        rsp_ready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 1;
        while (!rv1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("bp:latency", n, 3);
        w0 = wcnt;
        for (int i = 0; i < 5; i++) begin
            check("bp:rsp_valid", rv1, 1);
            check("bp:rsp_data", rdt1, 8'h8D);
            check("bp:cmd_ready", cr1, 0);
            cmd_valid = i[0];
            cmd_op    = 2'b01;
            cmd_data  = 8'h11;
            @(negedge clk);
        end
        check("bp:still_valid", rv1, 1);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp:rsp_valid_drop", rv1, 0);
        check("bp:ready_again", cr1, 1);
        check("bp:no_write", wcnt - w0, 0);
        check("bp:reg_unchanged", q1, 8'h8D);

        // Stuck-at-0 on bit 0: every verify mismatches, counter saturates
        stuck = 1'b1;
        do_cmd("wv_stuck_first", 2'b11, 8'hDD, 8'hDC, 1'b1, 4);
        for (int i = 1; i < 300; i++) do_cmd("wv_stuck", 2'b11, 8'hDD, 8'hDC, 1'b1, 4);
        check("sat:err_count", ec1, 255);
        stuck = 1'b0;

        // Reset during WRITE_VERIFY's WAIT state
        w0 = wcnt;
        r0 = rcnt;
        cmd_op    = 2'b11;
        cmd_data  = 8'h42;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midrst:in_wait", {busy1, we1, re1}, 3'b100);
        #2;
        rst = 1'b0;
        #1;
        check("midrst:outs_zero", {cr1, we1, re1, wd1, rv1, rdt1, rerr1, busy1}, 0);
        check("midrst:err_count", ec1, 0);
        exp_ec = 0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst:ready_before_edge", cr1, 0);
        @(negedge clk);
        check("midrst:ready_after_edge", cr1, 1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (rv1 || busy1) seen = 1'b1;
            @(negedge clk);
        end
        check("midrst:no_response", seen, 0);
        check("midrst:w_pulses", wcnt - w0, 1);
        check("midrst:r_pulses", rcnt - r0, 1);

        // RD_LAT=3 instance
        sel = 1'b1;
        #1;
        do_cmd("read_lat3", 2'b10, 8'h00, 8'h3C, 1'b0, 5);

        check("never_overlap", overlap, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_access_master.md
Name: reg_access_master

Overview:
- Command-driven initiator for the single-register read/write interface (clk, rst, r_en, w_en, in, out).
- Turns host commands (write, read, write-then-verify) into correctly timed reg_w_en/reg_r_en/reg_wdata pulses.
- Captures reg_rdata after a fixed read latency and returns one response per command over a valid/ready channel.
- Sits between a host/sequencer and one WIDTH-bit register instance.

Parameters:
- WIDTH, 8, data width of the register and the command/response data.
- RD_LAT, 1, cycles from the r_en cycle to valid reg_rdata; legal range 1..4.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  master can accept a command.
- cmd_op  input  2  00 NOP, 01 WRITE, 10 READ, 11 WRITE_VERIFY.
- cmd_data  input  WIDTH  write data; ignored for READ and NOP.
- reg_w_en  output  1  write strobe to the register.
- reg_r_en  output  1  read strobe to the register.
- reg_wdata  output  WIDTH  data driven to the register's in port.
- reg_rdata  input  WIDTH  register's out port.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  host accepts the response.
- rsp_data  output  WIDTH  response data.
- rsp_err  output  1  verify mismatch flag for the current response.
- busy  output  1  command in flight (state not IDLE).
- err_count  output  8  saturating count of verify mismatches.

Behaviour:
- Reset: rst low asynchronously forces state=IDLE and all outputs to 0, including cmd_ready, err_count and the latched op/data.
  - cmd_ready rises at the first rising clk edge after rst goes high.
- All outputs decode from registered state/data only. No combinational path from any input to any output.
- States: IDLE, WR, RD, WAIT, RSP.
- IDLE:
  - cmd_ready=1; all other outputs 0 (rsp_data holds its last value).
  - On the edge where cmd_valid&&cmd_ready, latch op and data, then branch:
    - NOP -> RSP.
    - WRITE or WRITE_VERIFY -> WR.
    - READ -> RD.
- WR:
  - Exactly one cycle with reg_w_en=1 and reg_wdata=latched data.
  - Next state: WRITE -> RSP with rsp_data=latched data; WRITE_VERIFY -> RD.
- RD:
  - Exactly one cycle with reg_r_en=1.
  - reg_wdata holds the latched data (0 for READ); reg_w_en=0.
  - Loads the latency counter with RD_LAT.
- WAIT:
  - Lasts RD_LAT cycles. reg_r_en and reg_w_en are both 0.
  - reg_rdata is sampled on the edge ending the last WAIT cycle, then -> RSP.
- RSP contents:
  - READ: rsp_data = sampled reg_rdata, rsp_err=0.
  - WRITE_VERIFY: rsp_data = sampled reg_rdata, rsp_err = (sampled != latched data).
  - WRITE: rsp_data = latched data, rsp_err=0.
  - NOP: rsp_data=0, rsp_err=0.
- RSP handshake:
  - rsp_valid=1; rsp_data and rsp_err stay stable until the rsp_valid&&rsp_ready edge, then -> IDLE.
  - cmd_ready=0 throughout, so no command overlap.
- reg_w_en and reg_r_en are never high in the same cycle, and each is high for exactly one cycle per access.
- Latency, counted from the accept edge, to rsp_valid high:
  - NOP: 1 cycle.
  - WRITE: 2 cycles.
  - READ: 2+RD_LAT cycles.
  - WRITE_VERIFY: 3+RD_LAT cycles.
- err_count increments by 1 on each response handshake with rsp_err=1 and saturates at 255.
- rsp_ready held high in IDLE or other states has no effect.
- cmd_valid while cmd_ready=0 is ignored; the command is not latched.
- Reset mid-operation: the in-flight command is dropped with no response and no further strobes; err_count clears.

Test Plan:
- Reset, then WRITE 0x9D with rsp_ready=1 -> reg_w_en high exactly 1 cycle with reg_wdata=0x9D; rsp_valid 2 cycles after accept; rsp_data=0x9D, rsp_err=0.
- READ with the register model holding 0x9D, RD_LAT=1 -> one reg_r_en pulse; rsp_valid 3 cycles after accept; rsp_data=0x9D.
- WRITE_VERIFY 0x8D on a good register -> w_en pulse, then r_en pulse on the next cycle; rsp_data=0x8D, rsp_err=0, err_count=0.
- WRITE_VERIFY 0xDD on a register model with bit 0 stuck at 0 -> rsp_data=0xDC, rsp_err=1, err_count=1.
  - Repeat 300 times -> err_count saturates at 255.
- READ with rsp_ready held low 5 cycles -> rsp_valid and rsp_data stable for all 5 cycles.
  - cmd_valid pulsed during those cycles is not accepted (cmd_ready=0).
  - Handshake -> IDLE, cmd_ready=1 the next cycle.
- Assert rst low during a WRITE_VERIFY's WAIT state -> all outputs 0 immediately; no rsp_valid after release; cmd_ready=1 one edge after release.
  - Repeat READ with RD_LAT=3 -> rsp_valid at 5 cycles after accept.
